imem_loader: RTL and testbench
==============================

# imem_loader

Writes a program image into the instruction memory from a byte stream. The block accepts bytes over a valid/ready interface, packs them little-endian into 32-bit instruction words, and issues one write per word at the next word address. It holds the CPU core in reset until a complete, valid image is in place. It is the write-side counterpart to the combinational, word-addressed instruction read path and sits between the boot/debug byte source (UART receiver or testbench) and the instruction memory write port.

## Interface
Parameters:
- DEPTH_WORDS, 64, instruction memory capacity in 32-bit words.
- ADDR_W, 32, width of the byte address driven on waddr.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous and active-high.
- start  in  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERR.
- byte_valid  in  1  source has a byte on byte_data.
- byte_data  in  8  stream byte.
- byte_ready  out  1  loader accepts a byte this cycle; a transfer occurs when byte_valid and byte_ready are both high.
- we  out  1  one-cycle write strobe to the instruction memory.
- waddr  out  ADDR_W  byte address, word-aligned: word_index*4, bits [1:0] always 0.
- wdata  out  32  instruction word.
- busy  out  1  a load is in progress.
- done  out  1  sticky; the image loaded successfully.
- error  out  1  sticky; the load was aborted.
- cpu_hold  out  1  high keeps the core in reset.

## Operation
- Stream format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4*N data bytes, least-significant byte of each word first.
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, CHK (only when the macro is defined), DONE, ERR.
- IDLE/DONE/ERR to LEN_LO on start. This clears done, clears error, zeroes word_index and the byte counter, and sets cpu_hold.
- LEN_LO to LEN_HI on a byte transfer.
- LEN_HI on a byte transfer:
  - N == 0: go to DONE (or CHK).
  - N > DEPTH_WORDS: go to ERR.
  - Otherwise: go to DATA.
- DATA: a 2-bit byte counter selects the byte lane.
  - On the 4th byte, the assembled word is registered onto wdata and we pulses for one cycle with waddr = word_index<<2. word_index then increments.
  - After word N-1 is written, go to DONE (or CHK).
- DONE: done=1, cpu_hold=0.
- ERR: error=1, cpu_hold=1.
- byte_ready=1 only in LEN_LO, LEN_HI, DATA and CHK. It is 0 in IDLE, DONE and ERR, so extra bytes stall at the source.
- start while busy is ignored.
- word_index never wraps. The N > DEPTH_WORDS check makes word_index ≤ DEPTH_WORDS-1 on every write.
- byte_valid may drop mid-word. Partial-word state is held indefinitely and there is no timeout.

## Timing
- Reset values: byte_ready=0, we=0, waddr=0, wdata=0, busy=0, done=0, error=0, cpu_hold=1. The FSM resets to IDLE.
- All outputs are registered.
- we asserts in the cycle after the clock edge that accepts the 4th byte of a word. That is one cycle of latency, with waddr and wdata valid in the same cycle.
- Back-to-back bytes are sustained at one per cycle, giving one word write every 4 cycles.
- busy is high from the cycle after start through the last state before DONE/ERR.
- done or error rises in the cycle after the final transfer.
- For the last word, the final we pulse and done=1 appear in the same cycle.
- Reset asserted mid-load forces the reset values immediately, asynchronously. Already-written words are left in memory.
- start and a byte transfer in the same cycle while in DONE: the byte is not accepted (byte_ready=0) and the load begins.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - Adds the CHK state and one trailing byte after the data bytes (sent even when N=0).
  - The loader keeps a running XOR of all data bytes (excluding length bytes).
  - CHK accepts one byte: a match goes to DONE, a mismatch goes to ERR.
  - done and error are delayed by that one extra transfer.
- Undefined: no CHK state, no checksum byte, no XOR register.

## Structure
- Package imem_pkg:
  - IMEM_DEPTH_WORDS (default source for DEPTH_WORDS).
  - imem_loader_state_t state enum.
  - LEN_W=16 constant.
- Sub-module word_packer:
  - Owns the 2-bit lane counter and the 32-bit shift/assemble register.
  - Interface: in_valid, in_byte, clear; outputs word_valid, word.
  - Reset: clk/rst, asynchronous active-high.
- The FSM, address counter and checksum stay in imem_loader.

## Test plan
- Reset: assert rst mid-sequence -> cpu_hold=1, byte_ready=0, we=0, busy=0, done=0, error=0 immediately.
- Normal load: start; bytes 02 00 93 00 10 00 13 01 20 00 -> we at waddr 0x0 with wdata 0x00100093, then at waddr 0x4 with wdata 0x00200113. done=1 and cpu_hold=0 in the cycle of the last we.
- Zero length: start; bytes 00 00 -> no we, done=1. With the checksum macro, also send 00 -> done=1.
- Overflow: DEPTH_WORDS=64, length bytes 41 00 (N=65) -> no we, error=1, cpu_hold=1, byte_ready=0. A following start recovers to LEN_LO.
- Stall/backpressure: byte_valid toggled 1-0-0-1 inside a word -> the single we carries the correct word. In DONE, byte_valid held high -> byte_ready stays 0.
- Checksum (macro defined): data word 0x00100093 with checksum byte 0x83 -> done. Checksum byte 0x84 -> error=1, cpu_hold=1.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory loader (imem_loader, word_packer).
// Optional checksum state is used only when IMEM_LOADER_CHECKSUM_EN is defined.
package imem_pkg;

  localparam int IMEM_DEPTH_WORDS = 64;
  localparam int LEN_W            = 16;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CHK,
    DONE,
    ERR
  } imem_loader_state_t;

endpackage

// File: rtl/word_packer.sv
// Packs bytes little-endian into 32-bit words; word/word_valid are combinational on the 4th byte.
// No backpressure of its own: it takes a byte whenever in_valid is high; clear restarts at lane 0.
module word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  input  logic        clear,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  lane_q, lane_d;
  logic [23:0] shreg_q, shreg_d;

  always_comb begin
    lane_d  = lane_q;
    shreg_d = shreg_q;
    if (clear) begin
      lane_d  = 2'd0;
      shreg_d = 24'd0;
    end else if (in_valid) begin
      lane_d  = lane_q + 2'd1;
      shreg_d = {in_byte, shreg_q[23:8]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q  <= 2'd0;
      shreg_q <= 24'd0;
    end else begin
      lane_q  <= lane_d;
      shreg_q <= shreg_d;
    end
  end

  // The first three bytes sit in shreg_q; the 4th is still on the input.
  assign word_valid = in_valid && (lane_q == 2'd3);
  assign word       = {in_byte, shreg_q};

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction memory, one write per word, 1-cycle write latency.
// byte_ready is high only while loading; IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
import imem_pkg::*;

module imem_loader #(
  parameter int DEPTH_WORDS = IMEM_DEPTH_WORDS,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_hold
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam imem_loader_state_t END_ST = CHK;
`else
  localparam imem_loader_state_t END_ST = DONE;
`endif

  imem_loader_state_t state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  word_index_q, word_index_d;
  logic [LEN_W-1:0]  len_full;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              byte_ready_q, byte_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              cpu_hold_q, cpu_hold_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        chk_q, chk_d;
`endif

  logic        xfer;
  logic        pk_valid;
  logic        pk_clear;
  logic        pk_word_valid;
  logic [31:0] pk_word;

  assign xfer     = byte_valid && byte_ready_q;
  assign pk_valid = xfer && (state_q == DATA);
  assign len_full = {byte_data, len_lo_q};

  word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (pk_valid),
    .in_byte    (byte_data),
    .clear      (pk_clear),
    .word_valid (pk_word_valid),
    .word       (pk_word)
  );

  always_comb begin
    state_d      = state_q;
    len_lo_d     = len_lo_q;
    len_d        = len_q;
    word_index_d = word_index_q;
    we_d         = 1'b0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    pk_clear     = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk_d        = chk_q;
`endif

    unique case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d      = LEN_LO;
          word_index_d = '0;
          pk_clear     = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          chk_d        = 8'd0;
`endif
        end
      end
      LEN_LO: begin
        if (xfer) begin
          len_lo_d = byte_data;
          state_d  = LEN_HI;
        end
      end
      LEN_HI: begin
        if (xfer) begin
          len_d = len_full;
          if (len_full == '0)
            state_d = END_ST;
          else if (int'(len_full) > DEPTH_WORDS)
            state_d = ERR;
          else
            state_d = DATA;
        end
      end
      DATA: begin
        if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          chk_d = chk_q ^ byte_data;
`endif
          if (pk_word_valid) begin
            we_d         = 1'b1;
            waddr_d      = ADDR_W'({word_index_q, 2'b00});
            wdata_d      = pk_word;
            word_index_d = word_index_q + 1'b1;
            if (word_index_q == len_q - 1'b1)
              state_d = END_ST;
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: begin
        if (xfer)
          state_d = (byte_data == chk_q) ? DONE : ERR;
      end
`endif
      default: state_d = IDLE;
    endcase

    // Status outputs are registered copies of what the next state implies.
    byte_ready_d = (state_d == LEN_LO) || (state_d == LEN_HI) ||
                   (state_d == DATA)   || (state_d == CHK);
    busy_d       = byte_ready_d;
    done_d       = (state_d == DONE);
    error_d      = (state_d == ERR);
    cpu_hold_d   = (state_d != DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      len_lo_q     <= 8'd0;
      len_q        <= '0;
      word_index_q <= '0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= 32'd0;
      byte_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      cpu_hold_q   <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_q        <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      len_lo_q     <= len_lo_d;
      len_q        <= len_d;
      word_index_q <= word_index_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      byte_ready_q <= byte_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
      cpu_hold_q   <= cpu_hold_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk_q        <= chk_d;
`endif
    end
  end

  assign byte_ready = byte_ready_q;
  assign we         = we_q;
  assign waddr      = waddr_q;
  assign wdata      = wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign cpu_hold   = cpu_hold_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed and randomized image loads checked against a simple image model.
`timescale 1ns/1ps

module tb_imem_loader;

  localparam int DEPTH = 64;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CHK_ON = 1'b1;
`else
  localparam bit CHK_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'd0;
  logic        byte_ready;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        error;
  logic        cpu_hold;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] img[$];
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic        last_we_done;

  imem_loader #(.DEPTH_WORDS(DEPTH), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .cpu_hold   (cpu_hold)
  );

  always #5 clk = ~clk;

  // Memory-side observer: records every write strobe seen mid-cycle.
  always @(negedge clk) begin
    if (we) begin
      wr_addr.push_back(waddr);
      wr_data.push_back(wdata);
      last_we_done = done;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Offers one byte after a random idle gap; returns #1 after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int n;
    n = 0;
    repeat ($urandom_range(0, max_gap)) @(negedge clk);
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready) begin
      check("byte_accept_timeout", 64'(byte_ready), 64'd1);
      byte_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      byte_valid = 1'b0;
    end
  endtask

  // Reference: a valid image of n words lands at addresses 4*i with img[i];
  // n > DEPTH writes nothing and errors; a bad checksum errors after the writes.
  task automatic run_load(input string tag, input int n, input bit bad_chk,
                          input int max_gap, input bit do_start);
    bit         ovf;
    bit         exp_err;
    int         exp_n;
    logic [7:0] x;
    ovf     = (n > DEPTH);
    exp_err = ovf || (CHK_ON && bad_chk);
    exp_n   = ovf ? 0 : n;
    x       = 8'd0;
    wr_addr.delete();
    wr_data.delete();
    last_we_done = 1'b0;
    if (do_start) begin
      pulse_start();
      check({tag, "_busy"}, 64'(busy), 64'd1);
      check({tag, "_hold_busy"}, 64'(cpu_hold), 64'd1);
    end
    send_byte(8'(n), max_gap);
    send_byte(8'(n >> 8), max_gap);
    if (!ovf) begin
      for (int i = 0; i < n; i++)
        for (int k = 0; k < 4; k++) begin
          send_byte(img[i][8*k +: 8], max_gap);
          x = x ^ img[i][8*k +: 8];
        end
      if (CHK_ON)
        send_byte(bad_chk ? (x ^ 8'h07) : x, max_gap);
    end
    check({tag, "_done"}, 64'(done), 64'(!exp_err));
    check({tag, "_error"}, 64'(error), 64'(exp_err));
    check({tag, "_cpu_hold"}, 64'(cpu_hold), 64'(exp_err));
    check({tag, "_busy_end"}, 64'(busy), 64'd0);
    check({tag, "_ready_end"}, 64'(byte_ready), 64'd0);
    @(negedge clk);
    @(negedge clk);
    check({tag, "_we_pulse"}, 64'(we), 64'd0);
    check({tag, "_nwr"}, 64'(wr_addr.size()), 64'(exp_n));
    for (int i = 0; i < exp_n && i < wr_addr.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), 64'(wr_addr[i]), 64'(i * 4));
      check($sformatf("%s_data%0d", tag, i), 64'(wr_data[i]), 64'(img[i]));
    end
    if (exp_n > 0 && !CHK_ON)
      check({tag, "_done_with_last_we"}, 64'(last_we_done), 64'd1);
  endtask

  initial begin
    int n;
    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(byte_ready), 64'd0);
    check("rst_we", 64'(we), 64'd0);
    check("rst_waddr", 64'(waddr), 64'd0);
    check("rst_wdata", 64'(wdata), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_cpu_hold", 64'(cpu_hold), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", 64'(byte_ready), 64'd0);

    // Normal two-word load, back-to-back bytes.
    img = '{32'h00100093, 32'h00200113};
    run_load("normal", 2, 1'b0, 0, 1'b1);

    // In DONE, a held byte is not accepted, even in the cycle start arrives.
    byte_valid = 1'b1;
    byte_data  = 8'h01;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("done_stall_ready", 64'(byte_ready), 64'd0);
    end
    start = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    byte_valid = 1'b0;
    check("start_in_done_busy", 64'(busy), 64'd1);
    check("start_in_done_done", 64'(done), 64'd0);
    check("start_in_done_ready", 64'(byte_ready), 64'd1);
    // Loader now waits in LEN_LO; the good checksum for this word is 0x83.
    img = '{32'h00100093};
    run_load("after_done", 1, 1'b0, 2, 1'b0);

    // Zero length.
    img.delete();
    run_load("zero_len", 0, 1'b0, 1, 1'b1);

    // Overflow, then recovery with a fresh start.
    run_load("overflow65", 65, 1'b0, 0, 1'b1);
    img = '{32'hDEADBEEF};
    run_load("recover", 1, 1'b0, 0, 1'b1);

    // Full-depth image.
    img.delete();
    for (int i = 0; i < DEPTH; i++) img.push_back($urandom);
    run_load("full_depth", DEPTH, 1'b0, 0, 1'b1);

    if (CHK_ON) begin
      img = '{32'h00100093};
      run_load("bad_chk", 1, 1'b1, 0, 1'b1);
    end

    // Asynchronous reset in the middle of a word.
    pulse_start();
    send_byte(8'd3, 0);
    send_byte(8'd0, 0);
    send_byte(8'hAA, 0);
    send_byte(8'h55, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_ready", 64'(byte_ready), 64'd0);
    check("midrst_we", 64'(we), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_error", 64'(error), 64'd0);
    check("midrst_cpu_hold", 64'(cpu_hold), 64'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Randomized images with random stalls inside words.
    for (int r = 0; r < 10; r++) begin
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(65, 400)) : int'($urandom_range(1, 8));
      img.delete();
      if (n <= DEPTH)
        for (int i = 0; i < n; i++) img.push_back($urandom);
      run_load($sformatf("rand%0d", r), n, CHK_ON && ($urandom_range(0, 2) == 0), 3, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
